// File: rtl/axi4_lite_arbiter_2to1.sv
// Two-requester AXI4-Lite arbiter: one transaction in flight at a time, round-robin
// between requesters, alternating read/write within a requester.
module axi4_lite_arbiter_2to1 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  // requester 0
  input  logic                  s0_AWVALID,
  input  logic [ADDR_W-1:0]     s0_AWADDR,
  output logic                  s0_AWREADY,
  input  logic                  s0_WVALID,
  input  logic [DATA_W-1:0]     s0_WDATA,
  input  logic [DATA_W/8-1:0]   s0_WSTRB,
  output logic                  s0_WREADY,
  output logic                  s0_BVALID,
  output logic [1:0]            s0_BRESP,
  input  logic                  s0_BREADY,
  input  logic                  s0_ARVALID,
  input  logic [ADDR_W-1:0]     s0_ARADDR,
  output logic                  s0_ARREADY,
  output logic                  s0_RVALID,
  output logic [DATA_W-1:0]     s0_RDATA,
  output logic [1:0]            s0_RRESP,
  input  logic                  s0_RREADY,
  // requester 1
  input  logic                  s1_AWVALID,
  input  logic [ADDR_W-1:0]     s1_AWADDR,
  output logic                  s1_AWREADY,
  input  logic                  s1_WVALID,
  input  logic [DATA_W-1:0]     s1_WDATA,
  input  logic [DATA_W/8-1:0]   s1_WSTRB,
  output logic                  s1_WREADY,
  output logic                  s1_BVALID,
  output logic [1:0]            s1_BRESP,
  input  logic                  s1_BREADY,
  input  logic                  s1_ARVALID,
  input  logic [ADDR_W-1:0]     s1_ARADDR,
  output logic                  s1_ARREADY,
  output logic                  s1_RVALID,
  output logic [DATA_W-1:0]     s1_RDATA,
  output logic [1:0]            s1_RRESP,
  input  logic                  s1_RREADY,
  // downstream slave
  output logic                  m_AWVALID,
  output logic [ADDR_W-1:0]     m_AWADDR,
  input  logic                  m_AWREADY,
  output logic                  m_WVALID,
  output logic [DATA_W-1:0]     m_WDATA,
  output logic [DATA_W/8-1:0]   m_WSTRB,
  input  logic                  m_WREADY,
  input  logic                  m_BVALID,
  input  logic [1:0]            m_BRESP,
  output logic                  m_BREADY,
  output logic                  m_ARVALID,
  output logic [ADDR_W-1:0]     m_ARADDR,
  input  logic                  m_ARREADY,
  input  logic                  m_RVALID,
  input  logic [DATA_W-1:0]     m_RDATA,
  input  logic [1:0]            m_RRESP,
  output logic                  m_RREADY,
  output logic                  oGNT,
  output logic                  oBUSY
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_t;

  state_t     state;
  logic       gnt;
  logic       rr_ptr;
  logic [1:0] last_wr;   // per requester: last completed op was a write
  logic       aw_done;
  logic       w_done;

  logic elig0, elig1, win, win_w, win_r, win_is_wr;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // granted-requester view of the request side
  logic              g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic [ADDR_W-1:0] g_awaddr, g_araddr;
  logic [DATA_W-1:0] g_wdata;
  logic [DATA_W/8-1:0] g_wstrb;

  assign g_awvalid = gnt ? s1_AWVALID : s0_AWVALID;
  assign g_awaddr  = gnt ? s1_AWADDR  : s0_AWADDR;
  assign g_wvalid  = gnt ? s1_WVALID  : s0_WVALID;
  assign g_wdata   = gnt ? s1_WDATA   : s0_WDATA;
  assign g_wstrb   = gnt ? s1_WSTRB   : s0_WSTRB;
  assign g_bready  = gnt ? s1_BREADY  : s0_BREADY;
  assign g_arvalid = gnt ? s1_ARVALID : s0_ARVALID;
  assign g_araddr  = gnt ? s1_ARADDR  : s0_ARADDR;
  assign g_rready  = gnt ? s1_RREADY  : s0_RREADY;

  // winner and its operation, used only in IDLE
  assign elig0     = s0_AWVALID | s0_ARVALID;
  assign elig1     = s1_AWVALID | s1_ARVALID;
  assign win       = (elig0 & elig1) ? rr_ptr : elig1;
  assign win_w     = win ? s1_AWVALID : s0_AWVALID;
  assign win_r     = win ? s1_ARVALID : s0_ARVALID;
  assign win_is_wr = ~(win_r & (~win_w | last_wr[win]));

  assign aw_hs = m_AWVALID & m_AWREADY;
  assign w_hs  = m_WVALID  & m_WREADY;
  assign b_hs  = m_BVALID  & m_BREADY;
  assign ar_hs = m_ARVALID & m_ARREADY;
  assign r_hs  = m_RVALID  & m_RREADY;

  assign oGNT  = gnt;
  assign oBUSY = (state != IDLE);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rr_ptr  <= 1'b0;
      last_wr <= 2'b00;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (elig0 | elig1) begin
          gnt   <= win;
          state <= win_is_wr ? WADDR : RADDR;
        end
        WADDR: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= WRESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WRESP: if (b_hs) begin
          state        <= IDLE;
          rr_ptr       <= ~gnt;
          last_wr[gnt] <= 1'b1;
        end
        RADDR: if (ar_hs) state <= RRESP;
        RRESP: if (r_hs) begin
          state        <= IDLE;
          rr_ptr       <= ~gnt;
          last_wr[gnt] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // channel pass-through for the granted requester; everything else held at zero
  always_comb begin
    m_AWVALID  = 1'b0;
    m_AWADDR   = '0;
    m_WVALID   = 1'b0;
    m_WDATA    = '0;
    m_WSTRB    = '0;
    m_BREADY   = 1'b0;
    m_ARVALID  = 1'b0;
    m_ARADDR   = '0;
    m_RREADY   = 1'b0;
    s0_AWREADY = 1'b0;
    s0_WREADY  = 1'b0;
    s0_BVALID  = 1'b0;
    s0_BRESP   = 2'b00;
    s0_ARREADY = 1'b0;
    s0_RVALID  = 1'b0;
    s0_RDATA   = '0;
    s0_RRESP   = 2'b00;
    s1_AWREADY = 1'b0;
    s1_WREADY  = 1'b0;
    s1_BVALID  = 1'b0;
    s1_BRESP   = 2'b00;
    s1_ARREADY = 1'b0;
    s1_RVALID  = 1'b0;
    s1_RDATA   = '0;
    s1_RRESP   = 2'b00;
    unique case (state)
      WADDR: begin
        m_AWVALID = g_awvalid & ~aw_done;
        m_AWADDR  = g_awaddr;
        m_WVALID  = g_wvalid & ~w_done;
        m_WDATA   = g_wdata;
        m_WSTRB   = g_wstrb;
        if (gnt) begin
          s1_AWREADY = m_AWREADY & ~aw_done;
          s1_WREADY  = m_WREADY & ~w_done;
        end else begin
          s0_AWREADY = m_AWREADY & ~aw_done;
          s0_WREADY  = m_WREADY & ~w_done;
        end
      end
      WRESP: begin
        m_BREADY = g_bready;
        if (gnt) begin
          s1_BVALID = m_BVALID;
          s1_BRESP  = m_BRESP;
        end else begin
          s0_BVALID = m_BVALID;
          s0_BRESP  = m_BRESP;
        end
      end
      RADDR: begin
        m_ARVALID = g_arvalid;
        m_ARADDR  = g_araddr;
        if (gnt) s1_ARREADY = m_ARREADY;
        else     s0_ARREADY = m_ARREADY;
      end
      RRESP: begin
        m_RREADY = g_rready;
        if (gnt) begin
          s1_RVALID = m_RVALID;
          s1_RDATA  = m_RDATA;
          s1_RRESP  = m_RRESP;
        end else begin
          s0_RVALID = m_RVALID;
          s0_RDATA  = m_RDATA;
          s0_RRESP  = m_RRESP;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Bench for axi4_lite_arbiter_2to1: directed grant/backpressure/reset cases, then
// randomized traffic against a transaction-level arbitration and memory model.
module tb_axi4_lite_arbiter_2to1;

  localparam int MAXQ   = 16;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic        who;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  logic clk, rst;

  logic        s_awvalid[2], s_awready[2], s_wvalid[2], s_wready[2];
  logic        s_bvalid[2], s_bready[2], s_arvalid[2], s_arready[2];
  logic        s_rvalid[2], s_rready[2];
  logic [31:0] s_awaddr[2], s_wdata[2], s_araddr[2], s_rdata[2];
  logic [3:0]  s_wstrb[2];
  logic [1:0]  s_bresp[2], s_rresp[2];

  logic        m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_BVALID, m_BREADY;
  logic        m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
  logic [31:0] m_AWADDR, m_WDATA, m_ARADDR, m_RDATA;
  logic [3:0]  m_WSTRB;
  logic [1:0]  m_BRESP, m_RRESP;
  logic        oGNT, oBUSY;

  int n_vec = 0;
  int n_err = 0;

  // per-phase request lists, expected responses and memories
  logic [31:0] wa[2][MAXQ], wd[2][MAXQ], ra[2][MAXQ];
  logic [3:0]  ws[2][MAXQ];
  logic [1:0]  exp_b[2][MAXQ];
  logic [33:0] exp_r[2][MAXQ];
  logic [31:0] model_mem[16], sl_mem[16];
  txn_t        exp_q[$];

  axi4_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .iCLK(clk), .iRST(rst),
    .s0_AWVALID(s_awvalid[0]), .s0_AWADDR(s_awaddr[0]), .s0_AWREADY(s_awready[0]),
    .s0_WVALID(s_wvalid[0]), .s0_WDATA(s_wdata[0]), .s0_WSTRB(s_wstrb[0]), .s0_WREADY(s_wready[0]),
    .s0_BVALID(s_bvalid[0]), .s0_BRESP(s_bresp[0]), .s0_BREADY(s_bready[0]),
    .s0_ARVALID(s_arvalid[0]), .s0_ARADDR(s_araddr[0]), .s0_ARREADY(s_arready[0]),
    .s0_RVALID(s_rvalid[0]), .s0_RDATA(s_rdata[0]), .s0_RRESP(s_rresp[0]), .s0_RREADY(s_rready[0]),
    .s1_AWVALID(s_awvalid[1]), .s1_AWADDR(s_awaddr[1]), .s1_AWREADY(s_awready[1]),
    .s1_WVALID(s_wvalid[1]), .s1_WDATA(s_wdata[1]), .s1_WSTRB(s_wstrb[1]), .s1_WREADY(s_wready[1]),
    .s1_BVALID(s_bvalid[1]), .s1_BRESP(s_bresp[1]), .s1_BREADY(s_bready[1]),
    .s1_ARVALID(s_arvalid[1]), .s1_ARADDR(s_araddr[1]), .s1_ARREADY(s_arready[1]),
    .s1_RVALID(s_rvalid[1]), .s1_RDATA(s_rdata[1]), .s1_RRESP(s_rresp[1]), .s1_RREADY(s_rready[1]),
    .m_AWVALID(m_AWVALID), .m_AWADDR(m_AWADDR), .m_AWREADY(m_AWREADY),
    .m_WVALID(m_WVALID), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WREADY(m_WREADY),
    .m_BVALID(m_BVALID), .m_BRESP(m_BRESP), .m_BREADY(m_BREADY),
    .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARREADY(m_ARREADY),
    .m_RVALID(m_RVALID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RREADY(m_RREADY),
    .oGNT(oGNT), .oBUSY(oBUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic s_nz(input int n);
    return |{s_awready[n], s_wready[n], s_bvalid[n], s_bresp[n], s_arready[n],
             s_rvalid[n], s_rdata[n], s_rresp[n]};
  endfunction

  function automatic logic m_nz();
    return |{m_AWVALID, m_AWADDR, m_WVALID, m_WDATA, m_WSTRB, m_BREADY,
             m_ARVALID, m_ARADDR, m_RREADY};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      s_awvalid[n] = 1'b0; s_awaddr[n] = '0; s_wvalid[n] = 1'b0; s_wdata[n] = '0;
      s_wstrb[n] = '0; s_bready[n] = 1'b0; s_arvalid[n] = 1'b0; s_araddr[n] = '0;
      s_rready[n] = 1'b0;
    end
    m_AWREADY = 1'b0; m_WREADY = 1'b0; m_BVALID = 1'b0; m_BRESP = 2'b00;
    m_ARREADY = 1'b0; m_RVALID = 1'b0; m_RDATA = '0; m_RRESP = 2'b00;
  endtask

  // leaves the caller just after a rising edge with reset released
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_phase(input int nw0, input int nr0, input int nw1, input int nr1,
                           input bit directed);
    int   nw[2], nr[2], mw[2], mr[2], wi[2], ri[2], w;
    bit   aw_sent[2], w_sent[2], ar_sent[2], lo[2];
    bit   rr, hw, hr, dw, sl_aw, sl_w, sl_ar, open, done;
    bit   aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
    logic [3:0]  sl_wstrb;
    txn_t cur, t;

    nw[0] = nw0; nr[0] = nr0; nw[1] = nw1; nr[1] = nr1;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < MAXQ; k++) begin
        wa[n][k] = $urandom & 32'hFFFF_FFFC;
        wd[n][k] = $urandom;
        ws[n][k] = 4'($urandom);
        ra[n][k] = $urandom & 32'hFFFF_FFFC;
      end
    if (directed) begin
      wa[0][0] = 32'h1; wd[0][0] = 32'hDEAD_BEEF; ws[0][0] = 4'hF; ra[1][0] = 32'h1;
    end
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
      sl_mem[i]    = model_mem[i];
    end

    // transaction-level reference: who is served, in which order, with what result
    exp_q.delete();
    mw = '{0, 0}; mr = '{0, 0}; rr = 1'b0; lo = '{1'b0, 1'b0};
    while (mw[0] < nw[0] || mr[0] < nr[0] || mw[1] < nw[1] || mr[1] < nr[1]) begin
      hw = (mw[0] < nw[0]) || (mr[0] < nr[0]);
      hr = (mw[1] < nw[1]) || (mr[1] < nr[1]);
      w  = (hw && hr) ? int'(rr) : (hr ? 1 : 0);
      hw = mw[w] < nw[w];
      hr = mr[w] < nr[w];
      dw = !(hr && (!hw || lo[w]));
      if (dw) begin
        t = '{who: 1'(w), wr: 1'b1, addr: wa[w][mw[w]], data: wd[w][mw[w]], strb: ws[w][mw[w]]};
        if (t.addr[7:6] == 2'b11) exp_b[w][mw[w]] = 2'b10;
        else begin
          exp_b[w][mw[w]] = 2'b00;
          model_mem[t.addr[5:2]] = merge(model_mem[t.addr[5:2]], t.data, t.strb);
        end
        mw[w]++;
      end else begin
        t = '{who: 1'(w), wr: 1'b0, addr: ra[w][mr[w]], data: 32'h0, strb: 4'h0};
        exp_r[w][mr[w]] = {(t.addr[7:6] == 2'b11) ? 2'b10 : 2'b00, model_mem[t.addr[5:2]]};
        mr[w]++;
      end
      exp_q.push_back(t);
      rr    = (w == 0);
      lo[w] = dw;
    end

    wi = '{0, 0}; ri = '{0, 0};
    aw_sent = '{0, 0}; w_sent = '{0, 0}; ar_sent = '{0, 0};
    sl_aw = 0; sl_w = 0; sl_ar = 0; open = 0; b_hs = 0; r_hs = 0; cur = '0;
    sl_awaddr = '0; sl_wdata = '0; sl_araddr = '0; sl_wstrb = '0;
    done = (nw0 == 0) && (nr0 == 0) && (nw1 == 0) && (nr1 == 0);
    do_reset();

    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      // requesters keep their next request asserted; slave with random readiness
      if (b_hs) m_BVALID = 1'b0;
      if (r_hs) m_RVALID = 1'b0;
      for (int n = 0; n < 2; n++) begin
        s_awvalid[n] = (wi[n] < nw[n]) && !aw_sent[n];
        s_wvalid[n]  = (wi[n] < nw[n]) && !w_sent[n];
        s_awaddr[n]  = wa[n][wi[n]];
        s_wdata[n]   = wd[n][wi[n]];
        s_wstrb[n]   = ws[n][wi[n]];
        s_bready[n]  = ($urandom_range(0, 4) < 3);
        s_arvalid[n] = (ri[n] < nr[n]) && !ar_sent[n];
        s_araddr[n]  = ra[n][ri[n]];
        s_rready[n]  = ($urandom_range(0, 4) < 3);
      end
      m_AWREADY = !sl_aw && ($urandom_range(0, 1) == 1);
      m_WREADY  = !sl_w  && ($urandom_range(0, 1) == 1);
      m_ARREADY = !sl_ar && ($urandom_range(0, 1) == 1);
      if (sl_aw && sl_w && !m_BVALID && ($urandom_range(0, 1) == 1)) begin
        m_BVALID = 1'b1;
        m_BRESP  = (sl_awaddr[7:6] == 2'b11) ? 2'b10 : 2'b00;
        if (sl_awaddr[7:6] != 2'b11)
          sl_mem[sl_awaddr[5:2]] = merge(sl_mem[sl_awaddr[5:2]], sl_wdata, sl_wstrb);
      end
      if (sl_ar && !m_RVALID && ($urandom_range(0, 1) == 1)) begin
        m_RVALID = 1'b1;
        m_RDATA  = sl_mem[sl_araddr[5:2]];
        m_RRESP  = (sl_araddr[7:6] == 2'b11) ? 2'b10 : 2'b00;
      end

      @(negedge clk);
      aw_hs = m_AWVALID && m_AWREADY;
      w_hs  = m_WVALID && m_WREADY;
      ar_hs = m_ARVALID && m_ARREADY;
      b_hs  = m_BVALID && m_BREADY;
      r_hs  = m_RVALID && m_RREADY;
      check("exclusive", 80'(s_nz(0) & s_nz(1)), 0);
      check("aw_repeat", 80'(m_AWVALID & sl_aw), 0);
      check("w_repeat", 80'(m_WVALID & sl_w), 0);
      check("ar_repeat", 80'(m_ARVALID & sl_ar), 0);
      if ((aw_hs || w_hs || ar_hs) && !open) begin
        open = 1;
        if (exp_q.size() == 0) begin
          check("extra_txn", 1, 0);
          cur = '0;
        end else cur = exp_q.pop_front();
      end
      if (aw_hs) begin
        check("aw_chan", {oGNT, 1'b1, m_AWADDR}, {cur.who, cur.wr, cur.addr});
        sl_aw = 1; sl_awaddr = m_AWADDR;
      end
      if (w_hs) begin
        check("w_chan", {oGNT, 1'b1, m_WSTRB, m_WDATA}, {cur.who, cur.wr, cur.strb, cur.data});
        sl_w = 1; sl_wdata = m_WDATA; sl_wstrb = m_WSTRB;
      end
      if (ar_hs) begin
        check("ar_chan", {oGNT, 1'b0, m_ARADDR}, {cur.who, cur.wr, cur.addr});
        sl_ar = 1; sl_araddr = m_ARADDR;
      end
      if (b_hs) begin sl_aw = 0; sl_w = 0; open = 0; end
      if (r_hs) begin sl_ar = 0; open = 0; end
      for (int n = 0; n < 2; n++) begin
        if (s_awvalid[n] && s_awready[n]) aw_sent[n] = 1;
        if (s_wvalid[n] && s_wready[n]) w_sent[n] = 1;
        if (s_arvalid[n] && s_arready[n]) ar_sent[n] = 1;
        if (s_bvalid[n] && s_bready[n]) begin
          if (wi[n] >= nw[n]) check($sformatf("extra_b%0d", n), 1, 0);
          else begin
            check($sformatf("b_resp%0d", n), 80'(s_bresp[n]), 80'(exp_b[n][wi[n]]));
            wi[n]++;
          end
          aw_sent[n] = 0; w_sent[n] = 0;
        end
        if (s_rvalid[n] && s_rready[n]) begin
          if (ri[n] >= nr[n]) check($sformatf("extra_r%0d", n), 1, 0);
          else begin
            check($sformatf("r_beat%0d", n), {s_rresp[n], s_rdata[n]}, 80'(exp_r[n][ri[n]]));
            ri[n]++;
          end
          ar_sent[n] = 0;
        end
      end
      done = (wi[0] == nw[0]) && (ri[0] == nr[0]) && (wi[1] == nw[1]) && (ri[1] == nr[1]);
      @(posedge clk);
      #1;
    end
    if (!done) check("phase_done", 0, 1);
    check("txn_left", 80'(exp_q.size()), 0);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    @(negedge clk);
    check("rst_busy", 80'(oBUSY), 0);
    check("rst_gnt", 80'(oGNT), 0);
    check("rst_s0", 80'(s_nz(0)), 0);
    check("rst_s1", 80'(s_nz(1)), 0);
    check("rst_m", 80'(m_nz()), 0);
    @(posedge clk); #1;

    // s1 alone is granted, then reset lands mid-write
    s_awvalid[1] = 1; s_awaddr[1] = 32'h40; s_wvalid[1] = 1;
    s_wdata[1] = 32'h1234_5678; s_wstrb[1] = 4'hF;
    @(negedge clk);
    check("idle_quiet", 80'(m_nz()), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("gnt_aw", {m_AWVALID, m_AWADDR}, {1'b1, 32'h40});
    check("gnt_s1", 80'(oGNT), 1);
    check("gnt_busy", 80'(oBUSY), 1);
    check("ng_s0_quiet", 80'(s_nz(0)), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("mid_rst_busy", 80'(oBUSY), 0);
    check("mid_rst_gnt", 80'(oGNT), 0);
    check("mid_rst_m", 80'(m_nz()), 0);
    check("mid_rst_s1", 80'(s_nz(1)), 0);
    @(posedge clk); #1;

    // s0 write with AW/W accepted together, then a held-off SLVERR response
    do_reset();
    s_awvalid[0] = 1; s_awaddr[0] = 32'h1; s_wvalid[0] = 1;
    s_wdata[0] = 32'hDEAD_BEEF; s_wstrb[0] = 4'hF;
    m_AWREADY = 1; m_WREADY = 1;
    @(negedge clk);
    check("bp_idle", {m_AWVALID, m_WVALID}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_aw_w", {m_AWVALID, m_WVALID, m_WDATA, m_WSTRB}, {2'b11, 32'hDEAD_BEEF, 4'hF});
    check("bp_ready0", {s_awready[0], s_wready[0]}, 2'b11);
    check("bp_s1_quiet", 80'(s_nz(1)), 0);
    @(posedge clk); #1;
    s_awvalid[0] = 0; s_wvalid[0] = 0; m_AWREADY = 0; m_WREADY = 0;
    m_BVALID = 1; m_BRESP = 2'b10; s_bready[0] = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {s_bvalid[0], s_bresp[0], m_BREADY, oBUSY, m_AWVALID},
            {1'b1, 2'b10, 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    s_bready[0] = 1;
    @(negedge clk);
    check("bp_release", 80'(m_BREADY), 1);
    @(posedge clk); #1;
    s_bready[0] = 0; m_BVALID = 0; m_BRESP = 2'b00;
    @(negedge clk);
    check("bp_idle_after", {oBUSY, s_bvalid[0]}, 0);
    @(posedge clk); #1;

    run_phase(1, 0, 0, 1, 1'b1);  // s0 write then s1 read of the same word
    run_phase(2, 0, 2, 0, 1'b0);  // write contention from reset
    run_phase(3, 3, 0, 0, 1'b0);  // one requester with both kinds pending
    repeat (3)
      run_phase(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
